// File: rtl/clock_div_ctrl.sv
// Run/stop-controlled clock-enable generator with a programmable terminal-count divider.
//
// Ports
//   clkin       in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   level, honoured in IDLE: begin counting
//   stop        in   level, honoured in RUN: halt counting (beats terminal count)
//   cfg_valid   in   divisor update request
//   cfg_div     in   requested divisor (0 is stored as 1)
//   cfg_ready   out  a new divisor can be accepted
//   tick        out  one-cycle enable pulse, one per divisor period
//   clkout      out  50% square wave, toggles on every tick
//   busy        out  high while running
//   tick_count  out  wrapping count of ticks issued
//
// Divisor updates accepted while running are parked in a pending register and only take
// effect on a period boundary (terminal count or stop), so no period is ever truncated.
module clock_div_ctrl #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 100000000
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             clkout,
  output logic             busy,
  output logic [15:0]      tick_count
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_div_q;
  logic             pend_q;
  logic             tick_q;
  logic             clkout_q;
  logic [15:0]      tick_count_q;

  logic             cfg_fire;
  logic [WIDTH-1:0] cfg_div_fixed;
  logic             at_tc;

  always_comb begin
    // A pending update holds off further requests until it has been applied.
    cfg_fire      = cfg_valid && !pend_q;
    cfg_div_fixed = (cfg_div == '0) ? WIDTH'(1) : cfg_div;
    // div_q is never 0, so div_q - 1 cannot wrap.
    at_tc         = (cnt_q == div_q - WIDTH'(1));
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      div_q        <= DEFAULT_DIV;
      pend_div_q   <= '0;
      pend_q       <= 1'b0;
      tick_q       <= 1'b0;
      clkout_q     <= 1'b0;
      tick_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tick_q <= 1'b0;
          if (cfg_fire) begin
            div_q <= cfg_div_fixed;
          end
          if (start) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end
        end

        StRun: begin
          if (stop) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            clkout_q <= 1'b0;
            pend_q   <= 1'b0;
            // A request landing on the stop edge is applied along with any parked one;
            // the two cannot coexist because cfg_fire requires no pending value.
            if (cfg_fire) begin
              div_q <= cfg_div_fixed;
            end else if (pend_q) begin
              div_q <= pend_div_q;
            end
          end else if (at_tc) begin
            cnt_q        <= '0;
            tick_q       <= 1'b1;
            clkout_q     <= ~clkout_q;
            tick_count_q <= tick_count_q + 16'd1;
            if (pend_q) begin
              div_q  <= pend_div_q;
              pend_q <= 1'b0;
            end
            // Arriving on this boundary: parked for the following one.
            if (cfg_fire) begin
              pend_div_q <= cfg_div_fixed;
              pend_q     <= 1'b1;
            end
          end else begin
            cnt_q  <= cnt_q + WIDTH'(1);
            tick_q <= 1'b0;
            if (cfg_fire) begin
              pend_div_q <= cfg_div_fixed;
              pend_q     <= 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_ready  = ~pend_q;
  assign tick       = tick_q;
  assign clkout     = clkout_q;
  assign busy       = (state_q == StRun);
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_clock_div_ctrl.sv
module tb_clock_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic [31:0] cfg_div;
  logic        cfg_ready;
  logic        tick;
  logic        clkout;
  logic        busy;
  logic [15:0] tick_count;

  int checks = 0;
  int errors = 0;

  clock_div_ctrl #(
    .WIDTH      (32),
    .DEFAULT_DIV(32'd4)
  ) dut (
    .clkin     (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .clkout    (clkout),
    .busy      (busy),
    .tick_count(tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: elapsed cycles within the current period versus the active divisor.
  bit          m_ok;
  bit          m_run;
  bit          m_pend;
  bit          m_tick;
  bit          m_clk;
  int unsigned m_div;
  int unsigned m_pdiv;
  int unsigned m_el;
  int unsigned m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int unsigned nd;
    bit          fire;
    nd   = (cfg_div == 0) ? 1 : cfg_div;
    fire = cfg_valid && !m_pend;
    if (rst) begin
      m_ok = 1; m_run = 0; m_div = 4; m_pend = 0; m_el = 0;
      m_tick = 0; m_clk = 0; m_cnt = 0;
    end else if (!m_ok) begin
      m_tick = 0;
    end else if (!m_run) begin
      m_tick = 0;
      if (fire) m_div = nd;
      if (start) begin m_run = 1; m_el = 0; end
    end else if (stop) begin
      m_run = 0; m_tick = 0; m_clk = 0; m_el = 0;
      if (fire) m_div = nd;
      else if (m_pend) m_div = m_pdiv;
      m_pend = 0;
    end else begin
      m_el++;
      if (m_el == m_div) begin
        m_tick = 1; m_clk = !m_clk; m_cnt++; m_el = 0;
        if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
      end else begin
        m_tick = 0;
      end
      if (fire) begin m_pdiv = nd; m_pend = 1; end
    end
  endtask

  // One clock: model advances with the DUT edge, outputs compared shortly after,
  // returns at the falling edge where the caller may change inputs.
  task automatic step();
    logic [19:0] exp;
    logic [19:0] act;
    @(posedge clk);
    model_step();
    #2;
    if (m_ok) begin
      exp = {m_tick, m_clk, m_run, !m_pend, m_cnt[15:0]};
      act = {tick, clkout, busy, cfg_ready, tick_count};
      check("cycle_model", {12'd0, act}, {12'd0, exp});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; start = 0; stop = 0; cfg_valid = 0; cfg_div = 0;
    step();
    rst = 0;
  endtask

  task automatic next_tick(output int gap);
    gap = 0;
    do begin
      step();
      gap++;
    end while (!tick && gap < 64);
  endtask

  initial begin
    int g;
    m_ok = 0; m_run = 0; m_pend = 0; m_tick = 0; m_clk = 0;
    m_div = 4; m_pdiv = 0; m_el = 0; m_cnt = 0;

    // Reset defaults and basic period
    do_reset();
    check("rst_tick", {31'd0, tick}, 0);
    check("rst_clkout", {31'd0, clkout}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, cfg_ready}, 1);
    check("rst_count", {16'd0, tick_count}, 0);
    start = 1; step(); start = 0;
    check("start_busy", {31'd0, busy}, 1);
    next_tick(g);
    check("div4_gap1", g, 4);
    check("div4_cnt1", {16'd0, tick_count}, 1);
    check("div4_clk1", {31'd0, clkout}, 1);
    next_tick(g);
    check("div4_gap2", g, 4);
    check("div4_cnt2", {16'd0, tick_count}, 2);
    check("div4_clk2", {31'd0, clkout}, 0);

    // Divisor 0 stored as 1: tick every cycle
    do_reset();
    cfg_valid = 1; cfg_div = 0; step(); cfg_valid = 0;
    start = 1; step(); start = 0;
    for (int k = 1; k <= 4; k++) begin
      next_tick(g);
      check("div1_gap", g, 1);
      check("div1_cnt", {16'd0, tick_count}, k);
      check("div1_clk", {31'd0, clkout}, k % 2);
    end

    // Mid-run reconfig 5 -> 3
    do_reset();
    cfg_valid = 1; cfg_div = 5; start = 1; step(); cfg_valid = 0; start = 0;
    next_tick(g);
    check("recfg_gap5", g, 5);
    step(); step();
    cfg_valid = 1; cfg_div = 3; step(); cfg_valid = 0;
    check("recfg_ready_lo", {31'd0, cfg_ready}, 0);
    next_tick(g);
    check("recfg_rest", g, 2);
    check("recfg_ready_hi", {31'd0, cfg_ready}, 1);
    next_tick(g);
    check("recfg_gap3a", g, 3);
    next_tick(g);
    check("recfg_gap3b", g, 3);

    // Coincident handshake on terminal count
    do_reset();
    start = 1; step(); start = 0;
    next_tick(g);
    check("coin_gap_first", g, 4);
    step(); step(); step();
    cfg_valid = 1; cfg_div = 2; step(); cfg_valid = 0;
    check("coin_tick", {31'd0, tick}, 1);
    check("coin_ready_lo", {31'd0, cfg_ready}, 0);
    next_tick(g);
    check("coin_gap_old", g, 4);
    check("coin_ready_hi", {31'd0, cfg_ready}, 1);
    next_tick(g);
    check("coin_gap_new1", g, 2);
    next_tick(g);
    check("coin_gap_new2", g, 2);

    // Stop on terminal count, start+stop in IDLE
    do_reset();
    start = 1; step(); start = 0;
    next_tick(g);
    step(); step(); step();
    stop = 1; step();
    check("stop_tick", {31'd0, tick}, 0);
    check("stop_clkout", {31'd0, clkout}, 0);
    check("stop_busy", {31'd0, busy}, 0);
    check("stop_count", {16'd0, tick_count}, 1);
    start = 1; step(); start = 0; stop = 0;
    check("both_busy", {31'd0, busy}, 1);
    stop = 1; step(); stop = 0;
    check("restop_busy", {31'd0, busy}, 0);
    check("restop_count", {16'd0, tick_count}, 1);

    // tick_count wrap at divisor 1
    do_reset();
    cfg_valid = 1; cfg_div = 1; start = 1; step(); cfg_valid = 0; start = 0;
    repeat (65535) step();
    check("wrap_ffff", {16'd0, tick_count}, 32'hFFFF);
    check("wrap_tick", {31'd0, tick}, 1);
    step();
    check("wrap_zero", {16'd0, tick_count}, 0);

    // Reset mid-run discards pending divisor
    do_reset();
    start = 1; step(); start = 0;
    next_tick(g);
    step();
    cfg_valid = 1; cfg_div = 7; step(); cfg_valid = 0;
    check("mrst_pend", {31'd0, cfg_ready}, 0);
    rst = 1; step(); rst = 0;
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_ready", {31'd0, cfg_ready}, 1);
    check("mrst_count", {16'd0, tick_count}, 0);
    check("mrst_clkout", {31'd0, clkout}, 0);
    start = 1; step(); start = 0;
    next_tick(g);
    check("mrst_default_div", g, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_div_ctrl.md
# clock_div_ctrl

- Programmable, run/stop-controlled clock-enable generator that replaces free-running division in the lab project.
- Sequences a terminal-count divider, owns its divisor register, and accepts divisor updates from a valid/ready configuration port.
- Updates are applied only on a period boundary, so downstream logic never sees a truncated period.
- Outputs:
  - `tick`: a one-cycle enable pulse for logic in the `clkin` domain.
  - `clkout`: a 50% square wave for display/LED use.

## Interface

Parameters:
- `WIDTH`, 32: width of divisor and internal counter.
- `DEFAULT_DIV`, 100000000: divisor loaded at reset; must be ≥1.

Ports:
- `clkin`  in  1: sole clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: level; sampled in IDLE, begins counting.
- `stop`  in  1: level; sampled in RUN, halts counting.
- `cfg_valid`  in  1: divisor update request.
- `cfg_div`  in  WIDTH: requested divisor; a value of 0 is stored as 1.
- `cfg_ready`  out  1: high when a new divisor can be accepted.
- `tick`  out  1: one-cycle pulse, one per divisor period.
- `clkout`  out  1: toggles on every tick; period = 2×divisor.
- `busy`  out  1: high while in RUN.
- `tick_count`  out  16: number of ticks issued, wrapping.

## Operation

- Reset values (one edge with `rst`=1):
  - state IDLE, counter 0, `div_reg`=`DEFAULT_DIV`, pending flag 0.
  - `tick`=0, `clkout`=0, `cfg_ready`=1, `busy`=0, `tick_count`=0.
- States: IDLE, RUN.
- IDLE → RUN: on an edge with `start`=1. Counter is set to 0.
- RUN, each edge:
  - If `stop`=1: go to IDLE. Counter is set to 0, `tick` to 0, `clkout` to 0. Stop wins over terminal count, so no tick is issued on that edge.
  - Else if counter == `div_reg`−1 (terminal count): counter to 0, `tick` to 1, `clkout` toggles, `tick_count` increments.
  - Else: counter increments, `tick` to 0.
- `start` in RUN and `stop` in IDLE are ignored. If both are high, `stop` has priority in RUN and `start` is honoured in IDLE.
- Config handshake: a transfer occurs on an edge with `cfg_valid`=1 and `cfg_ready`=1. `cfg_div`=0 is stored as 1.
  - In IDLE: the divisor is written straight to `div_reg`. `cfg_ready` stays 1.
  - In RUN: the divisor is written to a pending register, the pending flag is set, and `cfg_ready` goes to 0.
- Pending apply:
  - At the next terminal-count edge, `div_reg` takes the pending value, the pending flag clears, and `cfg_ready` returns to 1.
  - The counter restarts from 0, so the first period under the new divisor is complete.
  - On a stop edge, the pending value is applied at that edge.
- Simultaneous events:
  - A handshake on the same edge as a terminal count goes to pending. It is applied at the following terminal count, not the current one.
  - A handshake on a stop edge is treated as a RUN-state transfer and applied together with the stop.
- `div_reg`=1: terminal count is reached every edge, so `tick` stays high continuously and `clkout` toggles every cycle.
- Counter width is WIDTH. The comparison uses `div_reg`−1 with no overflow because `div_reg`≥1.
- `tick_count` wraps from 0xFFFF to 0x0000. It is not cleared by start or stop.
- Mid-operation reset: all state returns to reset values at that edge. A pending divisor is discarded and `div_reg` returns to `DEFAULT_DIV`.

## Timing

- All outputs are registered. Nothing is combinational from inputs to outputs.
- Start latency: with `start` sampled at edge E0, the first `tick` is high during the cycle after edge E0+`div_reg`. Ticks then repeat every `div_reg` cycles.
- `busy` rises the cycle after the start edge and falls the cycle after the stop edge.
- `cfg_ready` falls the cycle after a RUN-state handshake. It rises the cycle after the applying terminal-count or stop edge.
- `clkout` changes only in the same cycle that `tick` is high, or at stop/reset, where it is forced to 0.

## Test plan

- **Reset defaults:** `DEFAULT_DIV`=4, `rst` high for 1 edge → all outputs at reset values, `cfg_ready`=1. Start → ticks exactly 4 cycles apart, `clkout` period 8 cycles, `tick_count` 1,2,3… after each tick.
- **Divisor 1 and 0:** `cfg_div`=0 written in IDLE, then start → `tick` held high every cycle, `clkout` toggles every cycle.
- **Mid-run reconfig:** `div_reg`=5, running; write `cfg_div`=3 two cycles after a tick → `cfg_ready` low. Current period completes at 5 cycles, subsequent ticks are 3 apart, `cfg_ready` is high again the cycle after the applying edge.
- **Coincident handshake:** `div_reg`=4; write `cfg_div`=2 on the terminal-count edge → next period is still 4 cycles, periods after that are 2.
- **Stop/start priority:** stop asserted on a terminal-count edge → no tick, `clkout`=0, `busy`=0, `tick_count` unchanged. `start` and `stop` both high in IDLE → enters RUN. Run 65536 ticks at divisor 1 → `tick_count` wraps to 0.
- **Reset mid-run:** pending divisor 7 present, `rst` pulsed → IDLE, pending discarded, `div_reg`=`DEFAULT_DIV`, `cfg_ready`=1, `tick_count`=0.
